// File: rtl/rv32i_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32i_pkg : shared RV32I core constants and types                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_if : register file access bundle (core side = master)        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface regfile_if
    import rv32i_pkg::*;
#(
    parameter int WIDTH = XLEN
) ();

    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [WIDTH-1:0]      wd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] dbg_ra;
    logic [WIDTH-1:0]      rd1;
    logic [WIDTH-1:0]      rd2;
    logic [WIDTH-1:0]      dbg_rd;
    logic [15:0]           wr_cnt;

    modport master (
        output we, rd, wd, rs1, rs2, dbg_ra,
        input  rd1, rd2, dbg_rd, wr_cnt
    );

    modport slave (
        input  we, rd, wd, rs1, rs2, dbg_ra,
        output rd1, rd2, dbg_rd, wr_cnt
    );

endinterface : regfile_if
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_rdport : combinational read port with optional write bypass  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_rdport
    import rv32i_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter bit BYPASS = 1'b0
) (
    input  wire logic [REG_ADDR_W-1:0]          addr,
    input  wire logic [NUM_REGS-1:0][WIDTH-1:0] regs,
    input  wire logic                           byp_we,
    input  wire logic [REG_ADDR_W-1:0]          byp_addr,
    input  wire logic [WIDTH-1:0]               byp_data,
    output logic      [WIDTH-1:0]               data
);

    // x0 takes priority over the bypass so a discarded x0 write never leaks out
    always_comb begin
        data = regs[addr];
        if (addr == REG_ZERO) begin
            data = '0;
        end else if (BYPASS && byp_we && (byp_addr == addr)) begin
            data = byp_data;
        end
    end

endmodule : regfile_rdport
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile : RV32I integer register file, 2 read + 1 debug read port    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile
    import rv32i_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter bit BYPASS = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    regfile_if.slave  bus
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [NUM_REGS-1:1][WIDTH-1:0] r_regs;
    logic [NUM_REGS-1:0][WIDTH-1:0] w_view;
    logic [15:0]                    r_wr_cnt;
    logic                           w_commit;

    assign w_commit = bus.we && (bus.rd != REG_ZERO);

    // x0 has no storage; the read ports see a constant-zero slot in its place
    assign w_view = {r_regs, {WIDTH{1'b0}}};

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_regs[i] <= '0;
            end else if (w_commit && (bus.rd == i[REG_ADDR_W-1:0])) begin
                r_regs[i] <= bus.wd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= '0;
        end else if (w_commit && (r_wr_cnt != c_CNT_MAX)) begin
            r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    assign bus.wr_cnt = r_wr_cnt;

    regfile_rdport #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_rdport_a (
        .addr     (bus.rs1),
        .regs     (w_view),
        .byp_we   (bus.we),
        .byp_addr (bus.rd),
        .byp_data (bus.wd),
        .data     (bus.rd1)
    );

    regfile_rdport #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_rdport_b (
        .addr     (bus.rs2),
        .regs     (w_view),
        .byp_we   (bus.we),
        .byp_addr (bus.rd),
        .byp_data (bus.wd),
        .data     (bus.rd2)
    );

    // Debug always observes committed state
    regfile_rdport #(.WIDTH(WIDTH), .BYPASS(1'b0)) u_rdport_dbg (
        .addr     (bus.dbg_ra),
        .regs     (w_view),
        .byp_we   (bus.we),
        .byp_addr (bus.rd),
        .byp_data (bus.wd),
        .data     (bus.dbg_rd)
    );

endmodule : regfile
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile : directed check of regfile, BYPASS=0 and BYPASS=1 copies |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_regfile;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    regfile_if #(.WIDTH(32)) if0 ();
    regfile_if #(.WIDTH(32)) if1 ();

    regfile #(.WIDTH(32), .BYPASS(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    regfile #(.WIDTH(32), .BYPASS(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_wr(input logic we, input logic [4:0] rd, input logic [31:0] wd);
        if0.we = we;  if0.rd = rd;  if0.wd = wd;
        if1.we = we;  if1.rd = rd;  if1.wd = wd;
    endtask

    task automatic set_rd(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] dbg);
        if0.rs1 = rs1;  if0.rs2 = rs2;  if0.dbg_ra = dbg;
        if1.rs1 = rs1;  if1.rs2 = rs2;  if1.dbg_ra = dbg;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        set_rd(5'd5, 5'd31, 5'd17);
        #1;
        chk("rst_rd1",    if0.rd1,           32'h0);
        chk("rst_rd2",    if0.rd2,           32'h0);
        chk("rst_dbg",    if0.dbg_rd,        32'h0);
        chk("rst_cnt",    {16'h0, if0.wr_cnt}, 32'h0);

        // Load some contents, then drop reset mid-cycle
        @(negedge clk);
        rst_n = 1'b1;
        set_wr(1'b1, 5'd10, 32'h1234_5678);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd10, 5'd10, 5'd10);
        #1;
        chk("pre_async_rd1", if0.rd1,             32'h1234_5678);
        chk("pre_async_cnt", {16'h0, if0.wr_cnt}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rd1",  if0.rd1,             32'h0);
        chk("async_dbg",  if1.dbg_rd,          32'h0);
        chk("async_cnt",  {16'h0, if1.wr_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First write after release
        set_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd0, 5'd5);
        #1;
        chk("x5_rd1",     if0.rd1,             32'hDEAD_BEEF);
        chk("x5_dbg",     if1.dbg_rd,          32'hDEAD_BEEF);
        chk("x5_cnt",     {16'h0, if0.wr_cnt}, 32'h1);

        // x0 write is discarded, even on the bypass path
        set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        set_rd(5'd0, 5'd0, 5'd0);
        #1;
        chk("x0_byp_rd1", if1.rd1,             32'h0);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("x0_rd1",     if0.rd1,             32'h0);
        chk("x0_cnt",     {16'h0, if0.wr_cnt}, 32'h1);

        // Dual-port read
        @(negedge clk);
        set_wr(1'b1, 5'd3, 32'hA);
        @(negedge clk);
        set_wr(1'b1, 5'd4, 32'hB);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd3, 5'd4, 5'd4);
        #1;
        chk("dual_rd1",   if0.rd1,             32'hA);
        chk("dual_rd2",   if0.rd2,             32'hB);
        chk("dual_cnt",   {16'h0, if1.wr_cnt}, 32'h3);

        // Read-during-write of x7
        @(negedge clk);
        set_wr(1'b1, 5'd7, 32'h1);
        @(negedge clk);
        set_wr(1'b1, 5'd7, 32'h2);
        set_rd(5'd7, 5'd0, 5'd7);
        #1;
        chk("rdw_b0_rd1", if0.rd1,             32'h1);
        chk("rdw_b1_rd1", if1.rd1,             32'h2);
        chk("rdw_b1_dbg", if1.dbg_rd,          32'h1);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("rdw_b0_post", if0.rd1,            32'h2);
        chk("rdw_b1_dbgp", if1.dbg_rd,         32'h2);
        chk("rdw_cnt",     {16'h0, if0.wr_cnt}, 32'h5);

        // Same address on all ports
        set_wr(1'b1, 5'd3, 32'hC);
        set_rd(5'd3, 5'd3, 5'd3);
        #1;
        chk("same_b1_rd1", if1.rd1,            32'hC);
        chk("same_b1_rd2", if1.rd2,            32'hC);
        chk("same_b0_rd1", if0.rd1,            32'hA);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("same_post",   if0.rd2,            32'hC);

        // Reset coincident with a write of x9
        @(negedge clk);
        set_wr(1'b1, 5'd9, 32'h55);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        set_wr(1'b1, 5'd9, 32'h77);
        set_rd(5'd9, 5'd9, 5'd9);
        #1;
        chk("rsthold_b1_byp", if1.rd1,         32'h77);
        chk("rsthold_b0_rd1", if0.rd1,         32'h0);
        chk("rsthold_b1_dbg", if1.dbg_rd,      32'h0);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("race_rd1",   if0.rd1,             32'h0);
        chk("race_dbg",   if1.dbg_rd,          32'h0);
        chk("race_cnt",   {16'h0, if0.wr_cnt}, 32'h0);

        // Counter saturation: 65537 committed writes in total
        @(negedge clk);
        set_wr(1'b1, 5'd1, 32'h11);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe",   {16'h0, if0.wr_cnt}, 32'hFFFE);
        @(posedge clk);
        #1;
        chk("sat_ffff",   {16'h0, if0.wr_cnt}, 32'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd1, 5'd0, 5'd1);
        #1;
        chk("sat_hold0",  {16'h0, if0.wr_cnt}, 32'hFFFF);
        chk("sat_hold1",  {16'h0, if1.wr_cnt}, 32'hFFFF);
        chk("sat_x1",     if0.rd1,             32'h11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_regfile
`default_nettype wire
